frame_filter: RTL and testbench
===============================

# frame_filter

Frame-filter engine that fills the display frame RAM scanned by the VGA video generator. On `start` it walks a WIDTH×HEIGHT 8-bit grayscale source image in raster order and fetches each pixel's 3×3 neighbourhood from a source RAM. It applies the selected filter and writes one result per pixel into the display RAM's write port. It runs in the same clock domain as the display RAM.

## Interface
- `WIDTH`, 100, image width in pixels
- `HEIGHT`, 100, image height in pixels
- `AW`, 14, address width; address = y*WIDTH + x
- `DW`, 8, pixel width
---
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a frame pass; sampled only in IDLE
- `mode`  in  2  filter select, latched on accepted start
- `busy`  out  1  high while a pass is in progress
- `done`  out  1  one-cycle pulse after the last write
- `src_addr`  out  AW  source RAM read address
- `src_q`  in  DW  source RAM data; synchronous read, valid one cycle after `src_addr`
- `dst_addr`  out  AW  display RAM write address
- `dst_data`  out  DW  display RAM write data
- `dst_wren`  out  1  display RAM write enable, one cycle per pixel

## Operation
- FSM states: IDLE, FETCH (9 cycles, tap k = 0..8), ACC (1 cycle), WRITE (1 cycle), DONE (1 cycle).
- IDLE with `start`=1: latch `mode`, clear x and y, go to FETCH.
- Tap order is row-major over (dy,dx), from (-1,-1) to (+1,+1). Tap 4 is the centre.
- Each tap coordinate is clamped to [0,WIDTH-1] and [0,HEIGHT-1], giving edge replication.
- FETCH cycle k drives `src_addr` for tap k. `src_q` is captured as tap k-1 in the following cycle, so tap 8 is captured in ACC.
- ACC registers the filter result. In WRITE, `dst_wren`=1, `dst_addr` = y*WIDTH + x, and `dst_data` = result.
- After WRITE: x increments. When x = WIDTH-1 it wraps to 0 and y increments. If (x,y) was (WIDTH-1,HEIGHT-1), go to DONE; otherwise go to FETCH.
- DONE: `done`=1 and `busy`=0, then return to IDLE.
- Filter modes, with taps c0..c8:
  - 00 copy: c4.
  - 01 Gaussian: (c0+2c1+c2+2c3+4c4+2c5+c6+2c7+c8)>>4. Use a 12-bit unsigned sum; truncate, no rounding.
  - 10 sharpen: 5c4−c1−c3−c5−c7. Use 12-bit signed arithmetic; clamp below 0 to 0 and above 255 to 255.
  - 11 invert: 255−c4.
- `start` is ignored in every state except IDLE, including DONE. `mode` changes during a pass have no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `dst_wren`=0, `src_addr`=0, `dst_addr`=0, `dst_data`=0; state IDLE; x=y=0.
- Start accepted in cycle 0 → `busy`=1 from cycle 1, and the first FETCH is in cycle 1.
- Each pixel takes 11 cycles. The write for pixel n occurs in cycle 11n+11.
- The last write is in cycle 11·WIDTH·HEIGHT, which is 110000 with the defaults. `done` is high in the next cycle.
- `dst_wren` is never high for more than one consecutive cycle. It fires exactly WIDTH·HEIGHT times per pass.
- `rst_n` low mid-pass forces all outputs to their reset values immediately, with no further writes. A later `start` restarts the pass at address 0.

## Test plan
- Reset: hold `rst_n`=0, then release → all outputs 0. No `dst_wren` appears without `start`.
- Copy on a ramp image (`src`[a] = a mod 256):
  - Pixel (0,0) taps read addresses 0,0,1,0,0,1,100,100,101.
  - `dst`[a] = a mod 256 for all 10000 addresses.
  - There are exactly 10000 `dst_wren` pulses, and `done` fires in cycle 110001.
- Gaussian on an image that is zero except 255 at (50,50) → `dst`(50,50)=63, (49,50)=31, (49,49)=15, all other pixels 0.
- Gaussian on an image that is zero except 200 at (0,0) → `dst`(0,0)=112.
- Sharpen:
  - Centre 255 with neighbours 0 → 255 (1275 clamped).
  - Centre 0 with neighbours 255 → 0 (clamped from negative).
  - Image with 200 only at (0,0) → `dst`(0,0)=255 (600 clamped) and `dst`(1,0)=0.
- Invert on the ramp image → `dst`[a] = 255 − (a mod 256). A second `start` pulse at cycle 500 is ignored: the pass still ends at 110001 with exactly 10000 writes.
- Drive `rst_n` low during pixel 500 → `dst_wren` and `busy` drop in the same cycle. A new copy pass after release writes addresses 0..9999 in order.

Source files
------------

// File: rtl/frame_filter.sv
// Frame-filter engine: walks the source image in raster order, fetches each 3x3
// neighbourhood (edge-replicated) and writes one filtered pixel to the display RAM.
module frame_filter #(
   parameter int WIDTH  = 100,
   parameter int HEIGHT = 100,
   parameter int AW     = 14,
   parameter int DW     = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [1:0]    mode,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] src_addr,
   input  logic [DW-1:0] src_q,
   output logic [AW-1:0] dst_addr,
   output logic [DW-1:0] dst_data,
   output logic          dst_wren
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_ACC   = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]    state;
   logic [3:0]    k;
   logic [1:0]    mode_r;
   logic [AW-1:0] x, y;
   logic [DW-1:0] tap [0:7];
   logic [DW-1:0] result;

   logic [DW-1:0] c [0:8];
   logic [11:0]   gsum;
   logic [11:0]   sraw;
   logic signed [11:0] ssum;
   logic [DW-1:0] filt;
   int            tx, ty;

   // Tap address: row-major (dy,dx) around (x,y), clamped to the image bounds
   always_comb begin
      tx = int'(x) + int'(k % 4'd3) - 1;
      ty = int'(y) + int'(k / 4'd3) - 1;
      if (tx < 0) tx = 0;
      else if (tx > WIDTH - 1) tx = WIDTH - 1;
      if (ty < 0) ty = 0;
      else if (ty > HEIGHT - 1) ty = HEIGHT - 1;
      src_addr = (state == S_FETCH) ? AW'(ty * WIDTH + tx) : '0;
   end

   // Tap 8 is still on the RAM output during ACC, so it feeds the filter directly
   always_comb begin
      for (int i = 0; i < 8; i++) c[i] = tap[i];
      c[8] = src_q;
      gsum = 12'(c[0]) + (12'(c[1]) << 1) + 12'(c[2]) + (12'(c[3]) << 1)
           + (12'(c[4]) << 2) + (12'(c[5]) << 1) + 12'(c[6]) + (12'(c[7]) << 1)
           + 12'(c[8]);
      sraw = 12'(c[4]) * 12'd5 - 12'(c[1]) - 12'(c[3]) - 12'(c[5]) - 12'(c[7]);
      ssum = $signed(sraw);
      filt = '0;
      case (mode_r)
         2'b00: filt = c[4];
         2'b01: filt = DW'(gsum >> 4);
         2'b10: begin
            if (ssum < 0)              filt = '0;
            else if (ssum > 12'sd255)  filt = {DW{1'b1}};
            else                       filt = DW'(sraw);
         end
         default: filt = {DW{1'b1}} - c[4];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         k      <= '0;
         mode_r <= '0;
         x      <= '0;
         y      <= '0;
         result <= '0;
         for (int i = 0; i < 8; i++) tap[i] <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               mode_r <= mode;
               x      <= '0;
               y      <= '0;
               k      <= '0;
               state  <= S_FETCH;
            end
            S_FETCH: begin
               if (k != 4'd0) tap[3'(k - 4'd1)] <= src_q;
               if (k == 4'd8) state <= S_ACC;
               else           k     <= k + 4'd1;
            end
            S_ACC: begin
               result <= filt;
               k      <= '0;
               state  <= S_WRITE;
            end
            S_WRITE: begin
               if (x == AW'(WIDTH - 1)) begin
                  x <= '0;
                  y <= y + 1'b1;
                  state <= (y == AW'(HEIGHT - 1)) ? S_DONE : S_FETCH;
               end else begin
                  x     <= x + 1'b1;
                  state <= S_FETCH;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs decode straight from state so an async reset clears them at once
   assign busy     = (state == S_FETCH) || (state == S_ACC) || (state == S_WRITE);
   assign done     = (state == S_DONE);
   assign dst_wren = (state == S_WRITE);
   assign dst_addr = dst_wren ? AW'(int'(y) * WIDTH + int'(x)) : '0;
   assign dst_data = dst_wren ? result : '0;

endmodule

// File: tb/tb_frame_filter.sv
// Bench for frame_filter: reduced image size, random and directed images checked
// against a neighbourhood-arithmetic reference model.
module tb_frame_filter;
   localparam int W  = 20;
   localparam int H  = 15;
   localparam int N  = W * H;
   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic          busy, done, dst_wren;
   logic [AW-1:0] src_addr, dst_addr;
   logic [7:0]    src_q, dst_data;

   logic [7:0] src_mem [N];
   int         dst_mem [N];
   int         checks = 0;
   int         errors = 0;
   int         taps_seen [9];

   frame_filter #(.WIDTH(W), .HEIGHT(H), .AW(AW), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .busy(busy), .done(done),
      .src_addr(src_addr), .src_q(src_q), .dst_addr(dst_addr), .dst_data(dst_data),
      .dst_wren(dst_wren)
   );

   always #5 clk = ~clk;

   always @(posedge clk) src_q <= (int'(src_addr) < N) ? src_mem[src_addr] : 8'hxx;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int pix(input int px, input int py);
      int cx = (px < 0) ? 0 : (px > W - 1) ? W - 1 : px;
      int cy = (py < 0) ? 0 : (py > H - 1) ? H - 1 : py;
      return int'(src_mem[cy * W + cx]);
   endfunction

   function automatic int model(input int px, input int py, input int m);
      int s;
      case (m)
         0: return pix(px, py);
         1: begin
            s = 0;
            for (int dy = -1; dy <= 1; dy++)
               for (int dx = -1; dx <= 1; dx++)
                  s += pix(px + dx, py + dy) * (dx == 0 ? 2 : 1) * (dy == 0 ? 2 : 1);
            return s / 16;
         end
         2: begin
            s = 5 * pix(px, py) - pix(px, py - 1) - pix(px - 1, py)
                - pix(px + 1, py) - pix(px, py + 1);
            return s < 0 ? 0 : (s > 255 ? 255 : s);
         end
         default: return 255 - pix(px, py);
      endcase
   endfunction

   task automatic fill(input int kind);
      for (int a = 0; a < N; a++)
         case (kind)
            0: src_mem[a] = 8'(a % 256);
            1: src_mem[a] = 8'($urandom_range(255));
            default: src_mem[a] = 8'd0;
         endcase
   endtask

   task automatic run_pass(input logic [1:0] m, input int extra_start, input bit tap_chk);
      int rel = 0, wr_cnt = 0, first_wr = -1, done_rel = -1;
      int consec = 0, order_bad = 0, busy1 = -1, busy_at_done = -1;
      bit prev = 1'b0;
      for (int a = 0; a < N; a++) dst_mem[a] = -1;
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      for (int g = 0; g < 11 * N + 30; g++) begin
         @(negedge clk);
         rel++;
         start = (rel == extra_start);
         mode  = 2'($urandom);
         if (rel == 1) busy1 = int'(busy);
         if (tap_chk && rel <= 9) taps_seen[rel - 1] = int'(src_addr);
         if (dst_wren) begin
            if (first_wr < 0) first_wr = rel;
            if (prev) consec++;
            if (int'(dst_addr) != wr_cnt) order_bad++;
            if (int'(dst_addr) < N) dst_mem[dst_addr] = int'(dst_data);
            wr_cnt++;
         end
         prev = dst_wren;
         if (done) begin
            done_rel = rel;
            busy_at_done = int'(busy);
            break;
         end
      end
      start = 1'b0;
      chk("busy_cycle1", busy1, 1);
      chk("first_write_cycle", first_wr, 11);
      chk("done_cycle", done_rel, 11 * N + 1);
      chk("write_count", wr_cnt, N);
      chk("wren_consecutive", consec, 0);
      chk("write_order", order_bad, 0);
      chk("busy_at_done", busy_at_done, 0);
      @(negedge clk);
      chk("idle_after_done", int'({busy, done, dst_wren}), 0);
      for (int a = 0; a < N; a++)
         chk($sformatf("m%0d_px%0d", m, a), dst_mem[a], model(a % W, a / W, int'(m)));
   endtask

   initial begin
      int idle_wr;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_wren", int'(dst_wren), 0);
      chk("rst_src_addr", int'(src_addr), 0);
      chk("rst_dst_addr", int'(dst_addr), 0);
      chk("rst_dst_data", int'(dst_data), 0);
      rst_n = 1'b1;
      idle_wr = 0;
      repeat (20) begin
         @(negedge clk);
         idle_wr += int'(dst_wren) + int'(busy);
      end
      chk("idle_no_activity", idle_wr, 0);

      // Copy on ramp, including the first pixel's tap addresses
      fill(0);
      run_pass(2'b00, -1, 1'b1);
      begin
         int exp_taps [9] = '{0, 0, 1, 0, 0, 1, W, W, W + 1};
         for (int i = 0; i < 9; i++) chk($sformatf("tap%0d_addr", i), taps_seen[i], exp_taps[i]);
      end

      // Gaussian impulse in the interior
      fill(2);
      src_mem[7 * W + 10] = 8'd255;
      run_pass(2'b01, -1, 1'b0);
      chk("gauss_centre", dst_mem[7 * W + 10], 63);
      chk("gauss_side", dst_mem[7 * W + 9], 31);
      chk("gauss_diag", dst_mem[6 * W + 9], 15);
      chk("gauss_far", dst_mem[0], 0);

      // Gaussian corner impulse
      fill(2);
      src_mem[0] = 8'd200;
      run_pass(2'b01, -1, 1'b0);
      chk("gauss_corner", dst_mem[0], 112);

      // Sharpen: isolated bright pixel and dark pixel in a bright ring
      fill(2);
      src_mem[5 * W + 5] = 8'd255;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++)
            src_mem[(10 + dy) * W + 14 + dx] = (dx == 0 && dy == 0) ? 8'd0 : 8'd255;
      run_pass(2'b10, -1, 1'b0);
      chk("sharp_hi_clamp", dst_mem[5 * W + 5], 255);
      chk("sharp_lo_clamp", dst_mem[10 * W + 14], 0);

      // Sharpen corner
      fill(2);
      src_mem[0] = 8'd200;
      run_pass(2'b10, -1, 1'b0);
      chk("sharp_corner", dst_mem[0], 255);
      chk("sharp_corner_right", dst_mem[1], 0);

      // Invert on ramp with a stray start mid-pass
      fill(0);
      run_pass(2'b11, 500, 1'b0);
      chk("invert_px0", dst_mem[0], 255);
      chk("invert_px257", dst_mem[257], 254);

      // Random images in every mode
      for (int m = 0; m < 4; m++) begin
         fill(1);
         run_pass(2'(m), -1, 1'b0);
      end

      // Reset during the write of pixel 50, then a fresh copy pass
      fill(1);
      @(negedge clk);
      start = 1'b1;
      mode  = 2'b00;
      @(negedge clk);
      start = 1'b0;
      repeat (11 * 50 + 10) @(negedge clk);
      chk("pre_reset_wren", int'(dst_wren), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_reset_wren", int'(dst_wren), 0);
      chk("mid_reset_busy", int'(busy), 0);
      chk("mid_reset_dst_addr", int'(dst_addr), 0);
      chk("mid_reset_src_addr", int'(src_addr), 0);
      idle_wr = 0;
      repeat (4) begin
         @(negedge clk);
         idle_wr += int'(dst_wren);
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         idle_wr += int'(dst_wren) + int'(busy);
      end
      chk("post_reset_quiet", idle_wr, 0);
      run_pass(2'b00, -1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
